axis_2_fifo_adapter: RTL
========================

# axis_2_fifo_adapter

Write-side companion of the FIFO-to-AXIS read adapter. It accepts an AXI-Stream slave interface and writes each beat into a synchronous FIFO as one packed word, {tuser, tlast, tdata}. The bit layout is the same one the read adapter unpacks, so a FIFO between the two forms a transparent AXIS channel. A two-entry skid buffer keeps tready registered and sustains one beat per cycle. A packet counter and an in-packet flag give the host visibility of the traffic.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 32, tdata width.
- FIFO_DATA_WIDTH, AXIS_DATA_WIDTH + 2, FIFO word width; fixed at AXIS_DATA_WIDTH + 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  single clock; all logic on rising edge.
  - rst  in  1  asynchronous active-high reset.
- AXIS slave:
  - i_axis_tuser  in  1  sideband bit.
  - i_axis_tdata  in  AXIS_DATA_WIDTH  payload.
  - i_axis_tlast  in  1  last beat of packet.
  - i_axis_tvalid  in  1  beat valid.
  - o_axis_tready  out  1  registered ready.
- FIFO write side:
  - o_fifo_data  out  FIFO_DATA_WIDTH  packed word: [W+1]=tuser, [W]=tlast, [W-1:0]=tdata, where W = AXIS_DATA_WIDTH.
  - o_fifo_w_stb  out  1  one-cycle write strobe per word.
  - i_fifo_full  in  1  FIFO cannot accept a write this cycle.
- Status:
  - o_pkt_count  out  16  count of tlast words written to the FIFO; wraps.
  - o_in_packet  out  1  high between acceptance of a non-last beat and acceptance of its tlast beat.

## Operation
- Internal storage:
  - Output register: out_valid, out_word.
  - Skid register: skid_valid, skid_word.
- Definitions:
  - accept = i_axis_tvalid & o_axis_tready.
  - drain = o_fifo_w_stb.
- Outputs:
  - o_fifo_w_stb = out_valid & ~i_fifo_full. This is combinational from registered state and i_fifo_full.
  - o_fifo_data = out_word, always; it is valid only when o_fifo_w_stb is high.
- State machine (occupancy):
  - EMPTY (neither register valid):
    - accept -> ONE; out_word <= in.
  - ONE (out_valid only):
    - accept & drain -> ONE; out_word <= in.
    - accept & ~drain -> FULL; skid_word <= in.
    - ~accept & drain -> EMPTY.
    - otherwise hold.
  - FULL (both valid):
    - drain -> ONE; out_word <= skid_word.
    - otherwise hold. accept cannot occur in FULL because tready is low.
- o_axis_tready is a register. Next value = 1 unless the next state is FULL.
- Packing: the input beat is packed as {i_axis_tuser, i_axis_tlast, i_axis_tdata} at accept time. No reordering, no drops.
- o_pkt_count increments by 1 on each cycle where drain & out_word[W] = 1. It wraps 0xFFFF -> 0x0000.
- o_in_packet:
  - Set on accept with tlast = 0.
  - Cleared on accept with tlast = 1. This takes priority; a single-beat packet leaves it low.
- tvalid with tready low: the beat is not captured, and the source must hold it (AXIS rule). The block does not check source stability.

## Timing
- Reset (async assert) values:
  - o_axis_tready = 0, o_fifo_w_stb = 0, o_fifo_data = 0.
  - o_pkt_count = 0, o_in_packet = 0.
  - State = EMPTY.
- After reset release, tready rises at the first rising edge of clk.
- Latency: a beat accepted at edge N is presented with o_fifo_w_stb high in cycle N+1, provided i_fifo_full is low.
- Throughput: one beat per cycle sustained while i_fifo_full stays low. tready never drops in this case.
- Backpressure:
  - i_fifo_full high with the output register valid, plus a new accept, moves the block to FULL. tready falls one cycle later.
  - Exactly one extra beat (held in skid) is absorbed.
- Recovery: the first drain in FULL moves skid to out and raises tready the next cycle. No bubble on the FIFO side.
- Simultaneous accept and drain in ONE: the new word replaces out_word. The count reflects the drained word.
- Reset mid-operation: buffered words are discarded, counter and flag are cleared, and no write strobe is issued during reset.

## Test plan
- Reset then idle: rst pulse, tvalid = 0 -> tready = 0 during reset, 1 one cycle after release; w_stb stays 0; pkt_count = 0.
- Streaming: 8 beats tdata 0x0..0x7, tuser = 0, tlast on beat 7, fifo never full -> 8 consecutive w_stb starting 1 cycle after the first accept. Words are 0x0_00000000 .. 0x1_00000007, i.e. tlast is bit 32 of the last word. pkt_count = 1; in_packet high from beat 0 to beat 7.
- Backpressure: hold i_fifo_full = 1 while streaming 0xA0, 0xA1, 0xA2 -> tready falls after two accepts; 0xA2 is held at the source. Release full -> writes 0xA0, 0xA1, 0xA2 in order with no loss or duplication.
- Sideband: single beat tuser = 1, tlast = 1, tdata = 0xDEADBEEF -> o_fifo_data = 0x3_DEADBEEF; pkt_count increments; in_packet remains 0.
- Counter wrap: force 65536 single-beat packets (or preload via a long run) -> pkt_count returns to 0x0000.
- Reset mid-packet: assert rst while in FULL -> all outputs take their reset values immediately. No stale word is written after release.

Source files
------------

// File: rtl/axis_2_fifo_adapter.sv
`timescale 1ns/1ps
// axis_2_fifo_adapter: AXI-Stream slave feeding a synchronous FIFO write port.
// Each beat is packed as {tuser, tlast, tdata} behind a two-entry skid buffer.
module axis_2_fifo_adapter #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_axis_tuser,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
  input  logic                       i_axis_tlast,
  input  logic                       i_axis_tvalid,
  output logic                       o_axis_tready,
  output logic [FIFO_DATA_WIDTH-1:0] o_fifo_data,
  output logic                       o_fifo_w_stb,
  input  logic                       i_fifo_full,
  output logic [15:0]                o_pkt_count,
  output logic                       o_in_packet
);

  localparam int W = AXIS_DATA_WIDTH;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                     state_q, state_d;
  logic [FIFO_DATA_WIDTH-1:0] out_word_q, out_word_d;
  logic [FIFO_DATA_WIDTH-1:0] skid_word_q, skid_word_d;
  logic                       tready_q, tready_d;
  logic [15:0]                pkt_count_q, pkt_count_d;
  logic                       in_packet_q, in_packet_d;

  logic                       accept;
  logic                       drain;
  logic [FIFO_DATA_WIDTH-1:0] in_word;

  assign in_word = {i_axis_tuser, i_axis_tlast, i_axis_tdata};
  assign accept  = i_axis_tvalid & tready_q;
  assign drain   = (state_q != EMPTY) & ~i_fifo_full;

  assign o_axis_tready = tready_q;
  assign o_fifo_w_stb  = drain;
  assign o_fifo_data   = out_word_q;
  assign o_pkt_count   = pkt_count_q;
  assign o_in_packet   = in_packet_q;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave it unassigned and infer a latch.
    state_d     = state_q;
    out_word_d  = out_word_q;
    skid_word_d = skid_word_q;
    pkt_count_d = pkt_count_q;
    in_packet_d = in_packet_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          out_word_d = in_word;
        end
      end
      ONE: begin
        if (accept && drain) begin
          out_word_d = in_word;
        end else if (accept) begin
          state_d     = FULL;
          skid_word_d = in_word;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // tready is low here, so only the drain side can move.
        if (drain) begin
          state_d    = ONE;
          out_word_d = skid_word_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    tready_d = (state_d != FULL);

    if (drain && out_word_q[W]) pkt_count_d = pkt_count_q + 16'd1;
    if (accept)                 in_packet_d = ~i_axis_tlast;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, avoiding ordering races.
  // NOTE: the data words are reset as well, since o_fifo_data must read zero while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_word_q  <= '0;
      skid_word_q <= '0;
      tready_q    <= 1'b0;
      pkt_count_q <= '0;
      in_packet_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_word_q  <= out_word_d;
      skid_word_q <= skid_word_d;
      tready_q    <= tready_d;
      pkt_count_q <= pkt_count_d;
      in_packet_q <= in_packet_d;
    end
  end

endmodule
